// File: rtl/svk_ahb_rtl_pkg.sv
// svk_ahb_rtl_pkg: shared AHB encodings, slave FSM states and byte-lane helper
package svk_ahb_rtl_pkg;
  typedef enum logic [1:0] {HTRANS_IDLE, HTRANS_BUSY, HTRANS_NONSEQ, HTRANS_SEQ} htrans_e;
  typedef enum logic [1:0] {HRESP_OKAY, HRESP_ERROR} hresp_e;
  typedef enum logic [2:0] {HSIZE_BYTE, HSIZE_HALF, HSIZE_WORD, HSIZE_DWORD} hsize_e;
  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_RAW, ST_ERR1, ST_ERR2} state_e;
  function automatic logic [7:0] byte_strobe(input logic [2:0] size, input logic [2:0] addr);
    return (size == HSIZE_BYTE ? 8'h01 : size == HSIZE_HALF ? 8'h03 : size == HSIZE_WORD ? 8'h0f : 8'hff) << addr;
  endfunction
endpackage

// File: rtl/svk_ahb_sram_mem.sv
// svk_ahb_sram_mem: 1R1W synchronous-read RAM with per-byte write enables
module svk_ahb_sram_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH = 1024,
  localparam int NB = DATA_WIDTH / 8,
  localparam int IDX_W = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  re_i,
  input  logic [IDX_W-1:0]      raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  input  logic [NB-1:0]         we_i,
  input  logic [IDX_W-1:0]      waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i
);
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  always_ff @(posedge clk)
    for (int b = 0; b < NB; b++)
      if (we_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
  // read-before-write: a same-edge read sees the old word
  always_ff @(posedge clk)
    if (rst) rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  assign rdata_o = rdata_q;
endmodule

// File: rtl/svk_ahb_sram_slave.sv
// svk_ahb_sram_slave: AHB SRAM slave with programmable wait states and two-cycle ERROR responses
module svk_ahb_sram_slave
  import svk_ahb_rtl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [3:0]            hprot,
  input  logic [DATA_WIDTH-1:0] hwdata,
  input  logic                  hready_in,
  output logic [DATA_WIDTH-1:0] hrdata,
  output logic                  hready,
  output logic [1:0]            hresp
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_DEPTH * NB);
  localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES - 1);
  state_e state_q, state_d, launch;
  hresp_e hresp_q;
  logic [3:0] cnt_q, cnt_d;
  logic hready_q, dp_valid_q, dp_valid_d, dp_write_q;
  logic [IDX_W-1:0] dp_idx_q, idx;
  logic [2:0] dp_off_q, dp_size_q;
  logic acc, xfer, err, good, commit, raw;
  logic [7:0] strb;
  logic unused_ok;
  always_comb begin
    idx = haddr[OFF_W +: IDX_W];
    acc = hsel & hready_in & hready_q;
    xfer = acc & (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
    err = xfer & (haddr >= MEM_BYTES || hsize > 3'(OFF_W) || |(haddr[2:0] & ((3'd1 << hsize[1:0]) - 3'd1)));
    good = xfer & ~err;
    commit = dp_valid_q & dp_write_q & hready_q;
    raw = good & ~hwrite & commit & (idx == dp_idx_q);
    launch = err ? ST_ERR1 : raw ? ST_RAW : (good && WAIT_STATES > 0) ? ST_WAIT : ST_IDLE;
    state_d = state_q == ST_ERR1 ? ST_ERR2 :
              state_q == ST_WAIT ? (cnt_q == 4'd0 ? ST_IDLE : ST_WAIT) :
              state_q == ST_RAW  ? (WAIT_STATES > 0 ? ST_WAIT : ST_IDLE) : launch;
    cnt_d = (state_d == ST_WAIT && state_q != ST_WAIT) ? WS_LOAD :
            (state_q == ST_WAIT && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
    dp_valid_d = hready_q ? good : dp_valid_q;
    strb = byte_strobe(dp_size_q, dp_off_q & 3'(NB - 1));
  end
  always_ff @(posedge hclk)
    if (hreset) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      hready_q <= 1'b1;
      hresp_q <= HRESP_OKAY;
      dp_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      hready_q <= state_d == ST_IDLE || state_d == ST_ERR2;
      hresp_q <= (state_d == ST_ERR1 || state_d == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
      dp_valid_q <= dp_valid_d;
    end
  always_ff @(posedge hclk)
    if (acc) begin
      dp_write_q <= hwrite;
      dp_idx_q <= idx;
      dp_off_q <= haddr[2:0];
      dp_size_q <= hsize;
    end
  // RAW re-reads the stalled read's word once the colliding write has landed
  svk_ahb_sram_mem #(.DATA_WIDTH(DATA_WIDTH), .MEM_DEPTH(MEM_DEPTH)) u_mem (
    .clk     (hclk),
    .rst     (hreset),
    .re_i    (state_q == ST_RAW || (good && !hwrite)),
    .raddr_i (state_q == ST_RAW ? dp_idx_q : idx),
    .rdata_o (hrdata),
    .we_i    (strb[NB-1:0] & {NB{commit & ~hreset}}),
    .waddr_i (dp_idx_q),
    .wdata_i (hwdata)
  );
  assign hready = hready_q;
  assign hresp = hresp_q;
  assign unused_ok = ^{hburst, hprot, strb};
endmodule
